// File: rtl/sha1_pkg.sv
// Shared SHA-1 definitions: block geometry, padder FSM encoding,
// byte-swap helper and the padding mask/marker constants.
package sha1_pkg;

    localparam int SHA1_WORDS_PER_BLOCK = 16;
    localparam int SHA1_LEN_WORDS       = 2;

    // Mask keeps the r leading message bytes of a partial word; marker
    // places 0x80 in the byte just after them.
    localparam logic [31:0] PAD_MASK_R1   = 32'hFF00_0000;
    localparam logic [31:0] PAD_MASK_R2   = 32'hFFFF_0000;
    localparam logic [31:0] PAD_MASK_R3   = 32'hFFFF_FF00;
    localparam logic [31:0] PAD_MARKER_R1 = 32'h0080_0000;
    localparam logic [31:0] PAD_MARKER_R2 = 32'h0000_8000;
    localparam logic [31:0] PAD_MARKER_R3 = 32'h0000_0080;
    localparam logic [31:0] PAD_MARKER_W  = 32'h8000_0000;

    typedef enum logic [2:0] {
        PAD_IDLE    = 3'd0,
        PAD_FETCH   = 3'd1,
        PAD_CAPTURE = 3'd2,
        PAD_GEN     = 3'd3,
        PAD_HOLD    = 3'd4,
        PAD_FINISH  = 3'd5
    } pad_state_t;

    function automatic logic [31:0] bswap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    function automatic logic [31:0] pad_mask(input logic [1:0] r);
        logic [31:0] m;
        case (r)
            2'd1:    m = PAD_MASK_R1;
            2'd2:    m = PAD_MASK_R2;
            2'd3:    m = PAD_MASK_R3;
            default: m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] pad_marker(input logic [1:0] r);
        logic [31:0] m;
        case (r)
            2'd1:    m = PAD_MARKER_R1;
            2'd2:    m = PAD_MARKER_R2;
            2'd3:    m = PAD_MARKER_R3;
            default: m = 32'h0000_0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/sha1_msg_padder_if.sv
// Padded-word stream from the message padder to the compression stage.
//
// Handshake: a word transfers on a rising clk edge where word_valid and
// word_ready are both high. Once word_valid rises it stays high, and
// word_data/word_idx/block_last stay constant, until that transfer
// happens (reset is the only exception). word_ready may change freely
// and does not depend on word_valid.
interface sha1_msg_padder_if;

    logic        word_valid;
    logic        word_ready;
    logic [31:0] word_data;
    logic [3:0]  word_idx;
    logic        block_last;

    modport master (
        output word_valid,
        output word_data,
        output word_idx,
        output block_last,
        input  word_ready
    );

    modport slave (
        input  word_valid,
        input  word_data,
        input  word_idx,
        input  block_last,
        output word_ready
    );

endinterface

// File: rtl/sha1_pad_word_fmt.sv
// Combinational formatter: turns raw little-endian memory data plus the
// word position into the padded big-endian word W[i].
module sha1_pad_word_fmt
    import sha1_pkg::*;
#(
    parameter int SIZE_W = 32,
    parameter int CNT_W  = SIZE_W + 1
) (
    input  logic [31:0]       raw,
    input  logic [CNT_W-1:0]  i,
    input  logic [SIZE_W-1:0] sz,
    input  logic [CNT_W-1:0]  total,
    output logic [31:0]       word
);

    // One spare bit so the byte offset 4i+4 never wraps.
    localparam int OW = CNT_W + 3;

    logic [OW-1:0] off;
    logic [OW-1:0] sz_ext;
    logic [63:0]   bit_len;
    logic [31:0]   swapped;

    // Select the word's content from where byte offset 4i falls relative to the message end.
    always_comb begin
        off     = {1'b0, i, 2'b00};
        sz_ext  = OW'(sz);
        bit_len = 64'(sz) << 3;
        swapped = bswap(raw);
        word    = 32'h0000_0000;
        if (off + OW'(4) <= sz_ext) begin
            word = swapped;
        end else if (off < sz_ext) begin
            word = (swapped & pad_mask(sz[1:0])) | pad_marker(sz[1:0]);
        end else if (off == sz_ext) begin
            word = PAD_MARKER_W;
        end else if (i == total - CNT_W'(SHA1_LEN_WORDS)) begin
            word = bit_len[63:32];
        end else if (i == total - CNT_W'(1)) begin
            word = bit_len[31:0];
        end
    end

endmodule

// File: rtl/sha1_msg_padder.sv
// SHA-1 message padder: reads a little-endian message from dpsram port A
// and streams the padded message as big-endian words, 16 per block.
module sha1_msg_padder
    import sha1_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int SIZE_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [31:0]        message_addr,
    input  logic [SIZE_W-1:0]  message_size,
    output logic               port_A_clk,
    output logic               port_A_we,
    output logic [ADDR_W-1:0]  port_A_addr,
    output logic [31:0]        port_A_data_in,
    input  logic [31:0]        port_A_data_out,
    sha1_msg_padder_if.master  words,
    output logic               busy,
    output logic               done,
    output pad_state_t         dbg_state
);

    // Word counter is one bit wider than the size so 16*nblk always fits.
    localparam int CNT_W = SIZE_W + 1;

    pad_state_t        state;
    pad_state_t        next_state;
    logic [ADDR_W-1:0] base;
    logic [SIZE_W-1:0] sz;
    logic [CNT_W-1:0]  total;
    logic [CNT_W-1:0]  i;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;

    logic              handshake;
    logic              last_word;
    logic [CNT_W-1:0]  i_next;
    logic [CNT_W+2:0]  next_off;
    logic              next_needs_mem;
    logic [SIZE_W:0]   sum8;
    logic [SIZE_W:0]   nblk;
    logic [CNT_W-1:0]  total_calc;
    logic [31:0]       fmt_word;
    logic              addr_hi_unused;

    assign port_A_clk     = clk;
    assign port_A_we      = 1'b0;
    assign port_A_data_in = 32'h0000_0000;
    assign addr_hi_unused = ^message_addr[31:ADDR_W];

    // Handshake, end-of-stream and block-count arithmetic shared by the FSM and datapath.
    always_comb begin
        handshake      = (state == PAD_HOLD) && words.word_ready;
        last_word      = (i == total - CNT_W'(1));
        i_next         = i + CNT_W'(1);
        next_off       = {1'b0, i_next, 2'b00};
        next_needs_mem = next_off < (CNT_W+3)'(sz);
        sum8           = {1'b0, message_size} + (SIZE_W+1)'(8);
        nblk           = (sum8 >> 6) + (SIZE_W+1)'(1);
        total_calc     = CNT_W'(nblk) << 4;
    end

    sha1_pad_word_fmt #(
        .SIZE_W (SIZE_W),
        .CNT_W  (CNT_W)
    ) u_fmt (
        .raw   (port_A_data_out),
        .i     (i),
        .sz    (sz),
        .total (total),
        .word  (fmt_word)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= PAD_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: memory words take FETCH+CAPTURE, pad words take GEN.
    always_comb begin
        next_state = state;
        unique case (state)
            PAD_IDLE: begin
                if (start) begin
                    next_state = (message_size != '0) ? PAD_FETCH : PAD_GEN;
                end
            end
            PAD_FETCH:   next_state = PAD_CAPTURE;
            PAD_CAPTURE: next_state = PAD_HOLD;
            PAD_GEN:     next_state = PAD_HOLD;
            PAD_HOLD: begin
                if (handshake) begin
                    if (last_word) begin
                        next_state = PAD_FINISH;
                    end else if (next_needs_mem) begin
                        next_state = PAD_FETCH;
                    end else begin
                        next_state = PAD_GEN;
                    end
                end
            end
            PAD_FINISH:  next_state = PAD_IDLE;
            default:     next_state = PAD_IDLE;
        endcase
    end

    // Datapath: latch the job at start, advance the word counter and read address, register formatted words.
    always_ff @(posedge clk) begin
        if (reset) begin
            base  <= '0;
            sz    <= '0;
            total <= '0;
            i     <= '0;
            addr  <= '0;
            data  <= '0;
        end else begin
            unique case (state)
                PAD_IDLE: begin
                    if (start) begin
                        base  <= message_addr[ADDR_W-1:0];
                        sz    <= message_size;
                        total <= total_calc;
                        i     <= '0;
                        if (message_size != '0) begin
                            addr <= message_addr[ADDR_W-1:0];
                        end
                    end
                end
                PAD_CAPTURE, PAD_GEN: begin
                    data <= fmt_word;
                end
                PAD_HOLD: begin
                    if (handshake && !last_word) begin
                        i <= i_next;
                        if (next_needs_mem) begin
                            addr <= base + ADDR_W'({i_next, 2'b00});
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded from state and the datapath registers.
    always_comb begin
        busy             = (state != PAD_IDLE) && (state != PAD_FINISH);
        done             = (state == PAD_FINISH);
        dbg_state        = state;
        port_A_addr      = addr;
        words.word_valid = (state == PAD_HOLD);
        words.word_data  = data;
        words.word_idx   = i[3:0];
        words.block_last = busy && (i >= total - CNT_W'(SHA1_WORDS_PER_BLOCK));
    end

endmodule

// File: doc/sha1_msg_padder.md
Name: sha1_msg_padder

Overview:
- Upstream feeder for the SHA-1 hash core.
- Reads a little-endian-packed message from the dpsram through port A.
- Applies byte-order swap and SHA-1 padding: the 0x80 marker, zero fill, and the 64-bit big-endian bit length.
- Streams the padded message as 32-bit big-endian words, 16 per block, over a valid/ready handshake. The compression stage consumes the words as W[0..15] without doing any padding arithmetic itself.

Parameters:
- ADDR_W, 16, width of port_A_addr; address arithmetic wraps modulo 2^ADDR_W.
- SIZE_W, 32, width of message_size in bytes.

Ports:
- clk  input  1  system clock; also drives port_A_clk.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; ignored unless the block is idle.
- message_addr  input  32  byte address of the first message word; only [ADDR_W-1:0] is used; word aligned.
- message_size  input  SIZE_W  message length in bytes.
- port_A_clk  output  1  equals clk.
- port_A_we  output  1  constant 0.
- port_A_addr  output  ADDR_W  dpsram read address.
- port_A_data_in  output  32  constant 0.
- port_A_data_out  input  32  dpsram read data, 1-cycle synchronous read latency.
- word_valid  output  1  word_data holds a valid padded word.
- word_ready  input  1  consumer accepts the word this cycle.
- word_data  output  32  padded word, big-endian.
- word_idx  output  4  index of the word within its block, 0..15.
- block_last  output  1  word belongs to the final block.
- busy  output  1  high from start acceptance until done.
- done  output  1  one-cycle pulse after the final word handshake.

Behaviour:
- Reset values: all outputs are 0, state is IDLE, port_A_addr is 0. Reset mid-operation aborts immediately; any pending word is discarded.
- Start: on start in IDLE, latch base = message_addr[ADDR_W-1:0] and size. Compute nblk = floor((size+8)/64)+1 and total = 16*nblk words. Set the word counter i=0 and raise busy.
- Word content, where sz = size:
  - 4i+4 <= sz: bswap(mem[base+4i]).
  - 4i < sz < 4i+4, r = sz%4: bswap(mem) AND mask_r OR marker_r. mask_r = FF000000 / FFFF0000 / FFFFFF00 for r = 1/2/3; marker_r = 00800000 / 00008000 / 00000080.
  - 4i == sz: 0x80000000.
  - i == total-2: sz >> 29.
  - i == total-1: sz << 3, truncated to 32 bits.
  - Otherwise: 0.
- bswap definition: {d[7:0], d[15:8], d[23:16], d[31:24]}.
- Memory is read only when 4i < sz.
- FSM states:
  - IDLE: wait for start.
  - FETCH: drive port_A_addr = base+4i; go to CAPTURE.
  - CAPTURE: port_A_data_out is valid; format the word into the output register, set word_valid; go to HOLD.
  - GEN: pad word with no read; format the word, set word_valid; go to HOLD.
  - HOLD: wait for word_valid && word_ready. On the handshake, i++. Next state is FETCH if the next word needs memory, else GEN. If the accepted word was i == total-1, go to FINISH instead.
  - FINISH: pulse done, clear busy, go to IDLE.
- Output stability: word_data, word_idx and block_last are stable while word_valid is high and word_ready is low. word_valid is never withdrawn without a handshake, except on reset.
- Derived outputs: word_idx = i[3:0]; block_last = (i >= total-16).
- Latency: start to first word_valid is 3 cycles with a memory word (IDLE→FETCH→CAPTURE), 2 cycles for sz == 0.
- Throughput: with word_ready held high, one word per 3 cycles for message words and one per 2 cycles for pad words.
- Boundaries:
  - sz = 0 gives 1 block.
  - sz = 55 gives 1 block, with the marker in word 13 and the length in word 15.
  - sz = 56 gives 2 blocks.
  - sz = 64 gives 2 blocks, with the marker at word 16.
  - A base address near 2^ADDR_W wraps.
  - start while busy is ignored.
  - start coincident with reset: reset wins.

Decomposition:
- Shared package sha1_pkg holds:
  - SHA1_WORDS_PER_BLOCK = 16 and SHA1_LEN_WORDS = 2;
  - the padder FSM state enum;
  - the bswap function and the mask/marker constants.
- One sub-module, sha1_pad_word_fmt: combinational word formatter taking (raw, i, sz, total) and producing the padded word. It is unit-testable standalone.

Test Plan:
- sz = 3, mem[0] = 0x00636261 ("abc"), base 0, ready held 1 → 16 words: W0 = 0x61626380, W1..W14 = 0, W15 = 0x00000018; block_last = 1 throughout; done pulses once.
- sz = 0 → W0 = 0x80000000, W1..W15 = 0; no memory read occurs (port_A_addr never leaves its idle value).
- sz = 56, mem filled with 0x03020100 + 0x04040404*k → 32 words: W14 = 0x80000000, W30 = 0, W31 = 0x000001C0; block_last rises at word 16.
- sz = 4, ready randomly deasserted → word_data held stable across stalls; W0 = bswap(mem[0]), W1 = 0x80000000, W15 = 0x00000020.
- base = 0xFFFC, sz = 8 → reads at 0xFFFC then 0x0000 (wrap); W2 = 0x80000000, W15 = 0x00000040.
- Mid-stream reset at word 5 → next cycle word_valid = 0, busy = 0; a fresh start then produces a correct stream.
